// File: rtl/run_mon_pkg.sv
// Shared types and constants for the run-control monitor.
package run_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSettle,
    StDone,
    StTimeout
  } run_mon_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, inc_i};
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = sum[W] ? '1 : sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor: counts cycles/commits from start, waits for a settled drain or a timeout.
// Define RUN_MON_STALL_CNT_EN to build the ROB stall counter; otherwise stall_count is tied to 0.
module run_monitor
  import run_mon_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned COMMIT_WIDTH  = 1,
  parameter int unsigned ROB_CNT_W     = 6,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SETTLE_CYCLES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_STAGES-1:0]   stage_valid,
  input  logic [31:0]             fetch_instr,
  input  logic [ROB_CNT_W-1:0]    rob_count,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic [CNT_W-1:0]        timeout_limit,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        retired_count,
  output logic [CNT_W-1:0]        drain_cycle,
  output logic [CNT_W-1:0]        stall_count
);

  localparam int unsigned SUM_W    = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SettleOne = 1;

  run_mon_state_e      state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]    drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmo_q, tmo_d;

  logic             drain_ok;
  logic             active;
  logic             tmo_hit;
  logic             cnt_clr;
  logic [SUM_W-1:0] commit_sum;

  assign drain_ok = (fetch_instr == NOP_INSTR) && (stage_valid == '0) && (rob_count == '0);
  assign active   = (state_q == StRun) || (state_q == StSettle);
  assign tmo_hit  = active && (timeout_limit != '0) && (cycle_count == timeout_limit);
  assign cnt_clr  = start && !active;

  always_comb begin
    commit_sum = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_sum = commit_sum + SUM_W'(commit_valid[i]);
    end
  end

  // The cycle counter holds on the timeout edge so it reports exactly the budget.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (active && !tmo_hit),
    .inc_i (CNT_W'(1)),
    .cnt_o (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (active),
    .inc_i (CNT_W'(commit_sum)),
    .cnt_o (retired_count)
  );

`ifdef RUN_MON_STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (active && (rob_count != '0) && (commit_valid == '0)),
    .inc_i (CNT_W'(1)),
    .cnt_o (stall_count)
  );
`else
  assign stall_count = '0;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    drain_d  = drain_q;
    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (start) begin
          state_d = StRun;
          drain_d = '0;
        end
      end
      StRun: begin
        if (tmo_hit) begin
          state_d = StTimeout;
        end else if (drain_ok) begin
          drain_d = cycle_count;
          if (SETTLE_CYCLES > 1) begin
            state_d  = StSettle;
            settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        if (tmo_hit) begin
          state_d = StTimeout;
        end else if (!drain_ok) begin
          state_d = StRun;
          drain_d = '0;
        end else begin
          settle_d = settle_q - SettleOne;
          if (settle_q == SettleOne) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun) || (state_d == StSettle);
    done_d = (state_d == StDone);
    tmo_d  = (state_d == StTimeout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign drain_cycle = drain_q;

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor: a default instance plus a 4-lane, 4-bit-counter instance.
module tb_run_monitor;

  localparam int unsigned Settle = 10;
  localparam int SelCyc = 0, SelRet = 1, SelDrn = 2, SelBusy = 3, SelDone = 4, SelTmo = 5;
  localparam int SelStall = 6, Wide = 8;

  logic        clk = 1'b0;
  logic        rst, start, start_w;
  logic [2:0]  stage_valid;
  logic [31:0] fetch_instr;
  logic [5:0]  rob_count;
  logic        cv;
  logic [3:0]  cv_w;
  logic [31:0] tlim;
  logic [3:0]  tlim_w;

  logic        busy, done, tmo;
  logic [31:0] cyc, ret, drn, stl;
  logic        busy_w, done_w, tmo_w;
  logic [3:0]  cyc_w, ret_w, drn_w, stl_w;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp, n_err, lat;

  always #5 clk = ~clk;

  run_monitor u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stage_valid   (stage_valid),
    .fetch_instr   (fetch_instr),
    .rob_count     (rob_count),
    .commit_valid  (cv),
    .timeout_limit (tlim),
    .busy          (busy),
    .done          (done),
    .timeout       (tmo),
    .cycle_count   (cyc),
    .retired_count (ret),
    .drain_cycle   (drn),
    .stall_count   (stl)
  );

  run_monitor #(.COMMIT_WIDTH(4), .CNT_W(4)) u_dut_w (
    .clk           (clk),
    .rst           (rst),
    .start         (start_w),
    .stage_valid   (stage_valid),
    .fetch_instr   (fetch_instr),
    .rob_count     (rob_count),
    .commit_valid  (cv_w),
    .timeout_limit (tlim_w),
    .busy          (busy_w),
    .done          (done_w),
    .timeout       (tmo_w),
    .cycle_count   (cyc_w),
    .retired_count (ret_w),
    .drain_cycle   (drn_w),
    .stall_count   (stl_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelCyc:          return cyc;
      SelRet:          return ret;
      SelDrn:          return drn;
      SelBusy:         return {31'b0, busy};
      SelDone:         return {31'b0, done};
      SelTmo:          return {31'b0, tmo};
      SelStall:        return stl;
      Wide + SelCyc:   return {28'b0, cyc_w};
      Wide + SelRet:   return {28'b0, ret_w};
      Wide + SelDrn:   return {28'b0, drn_w};
      Wide + SelBusy:  return {31'b0, busy_w};
      Wide + SelDone:  return {31'b0, done_w};
      Wide + SelTmo:   return {31'b0, tmo_w};
      Wide + SelStall: return {28'b0, stl_w};
      default:         return 32'hdead_beef;
    endcase
  endfunction

  function automatic void sb_push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endfunction

  function automatic void sb_push_zero(input string tag, input int base);
    for (int s = SelCyc; s <= SelStall; s++) sb_push(tag, base + s, 32'd0);
  endfunction

  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq($sformatf("%s[%0d]", e.tag, e.sel), observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_work();
    stage_valid = 3'b111;
    fetch_instr = 32'h00a0_0093;
    rob_count   = 6'd3;
  endtask

  task automatic set_drain();
    stage_valid = 3'b000;
    fetch_instr = 32'h0000_0013;
    rob_count   = 6'd0;
  endtask

  // Edges until done/timeout rises; an expired budget shows up as a latency mismatch.
  task automatic wait_exit(input bit wide, output int n);
    n = 0;
    while (n < 200 && !(wide ? (done_w | tmo_w) : (done | tmo))) begin
      tick();
      n++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b1; start_w = 1'b1;
    cv = 1'b0; cv_w = 4'b0; tlim = 32'd0; tlim_w = 4'd0;
    set_work();
    tick(); tick();
    sb_push_zero("reset", 0);
    sb_push_zero("reset_w", Wide);
    sb_check();
    rst = 1'b0; start = 1'b0; start_w = 1'b0;
    tick();
    sb_push("idle_hold", SelBusy, 0);
    sb_check();

    // Basic run: 20 busy cycles with 5 commits, then a held drain.
    start = 1'b1; tick(); start = 1'b0;
    sb_push("start", SelBusy, 1); sb_push("start", SelCyc, 0);
    sb_check();
    for (int i = 0; i < 20; i++) begin
      cv = (i % 4 == 1);
      tick();
    end
    cv = 1'b0;
    sb_push("run20", SelCyc, 20); sb_push("run20", SelRet, 5);
    sb_check();
    set_drain(); tick();
    sb_push("settle", SelBusy, 1); sb_push("settle", SelDrn, 20); sb_push("settle", SelDone, 0);
    sb_check();
    wait_exit(1'b0, lat);
    check_eq("basic_lat", lat, Settle - 1);
    sb_push("basic", SelDone, 1); sb_push("basic", SelBusy, 0); sb_push("basic", SelTmo, 0);
    sb_push("basic", SelCyc, 20 + Settle); sb_push("basic", SelRet, 5);
    sb_push("basic", SelDrn, 20);
`ifdef RUN_MON_STALL_CNT_EN
    sb_push("basic", SelStall, 15);
`else
    sb_push("basic", SelStall, 0);
`endif
    sb_check();
    cv = 1'b1; repeat (3) tick(); cv = 1'b0;
    sb_push("frozen", SelCyc, 20 + Settle); sb_push("frozen", SelRet, 5);
    sb_push("frozen", SelDone, 1);
    sb_check();

    // Broken settle: restart from DONE, drain 4 cycles, one ROB blip, drain again.
    set_work(); start = 1'b1; tick(); start = 1'b0;
    sb_push("restart", SelCyc, 0); sb_push("restart", SelRet, 0); sb_push("restart", SelDrn, 0);
    sb_push("restart", SelDone, 0); sb_push("restart", SelBusy, 1);
    sb_check();
    repeat (3) tick();
    set_drain(); tick();
    sb_push("drain1", SelDrn, 3);
    sb_check();
    repeat (3) tick();
    rob_count = 6'd1; tick();
    sb_push("blip", SelDrn, 0); sb_push("blip", SelBusy, 1); sb_push("blip", SelCyc, 8);
    sb_check();
    rob_count = 6'd0; tick();
    sb_push("drain2", SelDrn, 8);
    sb_check();
    wait_exit(1'b0, lat);
    check_eq("broken_lat", lat, Settle - 1);
    sb_push("broken", SelDone, 1); sb_push("broken", SelCyc, 18); sb_push("broken", SelDrn, 8);
`ifdef RUN_MON_STALL_CNT_EN
    sb_push("broken", SelStall, 4);
`else
    sb_push("broken", SelStall, 0);
`endif
    sb_check();

    // Timeout with a commit every cycle, including the edge that enters TIMEOUT.
    set_work(); tlim = 32'd50; cv = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_exit(1'b0, lat);
    check_eq("tmo_lat", lat, 51);
    sb_push("tmo", SelTmo, 1); sb_push("tmo", SelDone, 0); sb_push("tmo", SelBusy, 0);
    sb_push("tmo", SelCyc, 50); sb_push("tmo", SelRet, 51);
    sb_check();
    repeat (3) tick();
    sb_push("tmo_frozen", SelCyc, 50); sb_push("tmo_frozen", SelRet, 51);
    sb_push("tmo_frozen", SelTmo, 1);
    sb_check();
    cv = 1'b0;

    // Drain first seen on the same edge the budget expires: timeout wins.
    set_work(); start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    sb_push("tie_pre", SelCyc, 50); sb_push("tie_pre", SelBusy, 1);
    sb_check();
    set_drain(); tick();
    sb_push("tie", SelTmo, 1); sb_push("tie", SelDone, 0); sb_push("tie", SelBusy, 0);
    sb_push("tie", SelCyc, 50);
`ifdef RUN_MON_STALL_CNT_EN
    sb_push("tie", SelStall, 50);
`else
    sb_push("tie", SelStall, 0);
`endif
    sb_check();

    // Wide commit and 4-bit saturation.
    set_work(); start_w = 1'b1; tick(); start_w = 1'b0;
    cv_w = 4'b1011; repeat (3) tick();
    sb_push("wide", Wide + SelRet, 9); sb_push("wide", Wide + SelCyc, 3);
    sb_check();
    cv_w = 4'b1111; repeat (2) tick(); cv_w = 4'b0000;
    repeat (15) tick();
    sb_push("sat", Wide + SelCyc, 15); sb_push("sat", Wide + SelRet, 15);
    sb_push("sat", Wide + SelBusy, 1);
    sb_check();
    set_drain(); tick();
    sb_push("sat_drain", Wide + SelDrn, 15);
    sb_check();
    wait_exit(1'b1, lat);
    check_eq("sat_lat", lat, Settle - 1);
    sb_push("sat_done", Wide + SelDone, 1); sb_push("sat_done", Wide + SelCyc, 15);
    sb_push("sat_done", Wide + SelRet, 15);
    sb_check();
    set_work(); start_w = 1'b1; tick(); start_w = 1'b0;
    sb_push("w_restart", Wide + SelCyc, 0); sb_push("w_restart", Wide + SelRet, 0);
    sb_push("w_restart", Wide + SelDrn, 0); sb_push("w_restart", Wide + SelDone, 0);
    sb_push("w_restart", Wide + SelBusy, 1);
    sb_check();
    set_drain(); repeat (3) tick();
    sb_push("w_settle", Wide + SelBusy, 1); sb_push("w_settle", Wide + SelDone, 0);
    sb_check();

    // Reset mid-SETTLE, with a simultaneous start that must be ignored.
    rst = 1'b1; start = 1'b1; start_w = 1'b1; tick();
    sb_push_zero("rst_mid", 0);
    sb_push_zero("rst_mid_w", Wide);
    sb_check();
    rst = 1'b0; start = 1'b0; start_w = 1'b0; tick();
    sb_push("post_rst", SelBusy, 0); sb_push("post_rst", Wide + SelBusy, 0);
    sb_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesisable run-control monitor for the OoO core. It counts cycles and retired instructions from a start pulse, detects pipeline drain, holds the drain for a configurable settle window, and flags completion or timeout. It sits beside `OoO_top` and takes per-stage valids, the fetched instruction, ROB occupancy and commit valids. It supports any number of front-end stages and any commit width.

## Interface
Parameters:
- `NUM_STAGES`, 3: number of front-end stage valids monitored (decode, rename, dispatch).
- `COMMIT_WIDTH`, 1: commit lanes per cycle.
- `ROB_CNT_W`, 6: width of the ROB occupancy count.
- `CNT_W`, 32: width of every counter.
- `SETTLE_CYCLES`, 10: consecutive drained cycles required before done.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a run.
- `stage_valid` in NUM_STAGES: valid bits of the monitored stages.
- `fetch_instr` in 32: instruction currently presented by fetch.
- `rob_count` in ROB_CNT_W: current ROB occupancy.
- `commit_valid` in COMMIT_WIDTH: per-lane commit strobes.
- `timeout_limit` in CNT_W: cycle budget for a run; 0 disables the timeout.
- `busy` out 1: high in RUN or SETTLE.
- `done` out 1: high in DONE.
- `timeout` out 1: high in TIMEOUT.
- `cycle_count` out CNT_W: cycles elapsed in the run.
- `retired_count` out CNT_W: instructions committed during the run.
- `drain_cycle` out CNT_W: `cycle_count` value at the start of the accepted drain.
- `stall_count` out CNT_W: cycles with a non-empty ROB and no commit (see Configuration).

## Operation
- States are IDLE, RUN, SETTLE, DONE, TIMEOUT. Reset puts the block in IDLE, drives all outputs to 0 and sets the settle counter to 0.
- The drain condition is: `fetch_instr == NOP_INSTR` (0x00000013), `stage_valid == 0` and `rob_count == 0`.
- **IDLE:** `start` moves to RUN and clears all counters and `drain_cycle`.
- **RUN:**
  - `cycle_count` increments by 1 each cycle.
  - `retired_count` increments by popcount(`commit_valid`) each cycle.
  - If the drain condition holds, capture `drain_cycle` = pre-increment `cycle_count`.
  - With the drain condition and SETTLE_CYCLES > 1, move to SETTLE and load the settle counter with SETTLE_CYCLES−1.
  - With the drain condition and SETTLE_CYCLES ≤ 1, move directly to DONE.
- **SETTLE:**
  - Counting continues as in RUN.
  - If the drain condition drops, return to RUN and clear `drain_cycle` to 0. Commits that arrive here are still counted.
  - Otherwise decrement the settle counter and move to DONE when it reaches 0.
- **Timeout:**
  - Applies in RUN or SETTLE when `timeout_limit` ≠ 0 and `cycle_count` == `timeout_limit` at the sampling edge.
  - The block moves to TIMEOUT, and this has priority over every drain or settle transition.
- **DONE / TIMEOUT:**
  - Sticky; all counters freeze.
  - `start` re-enters RUN with the counters cleared.
- `start` in RUN or SETTLE is ignored.
- All counters saturate at all-ones and never wrap.
- The popcount sum is COMMIT_WIDTH-safe (sum width is clog2(COMMIT_WIDTH+1)) and is zero-extended to CNT_W.

## Timing
- All outputs are registered.
- `start` sampled at edge N gives `busy`=1 and `cycle_count`=0 after edge N.
- After edge N+k with no exit, `cycle_count`=k.
- Drain first sampled at edge D gives `done` after edge D+SETTLE_CYCLES−1 if the drain holds, for SETTLE_CYCLES ≥ 1.
- The commit on the edge that enters DONE or TIMEOUT is counted; nothing after that edge is counted.
- `rst` during any state returns to IDLE on the next edge with outputs at 0. A `start` in the same cycle as `rst` is ignored.

## Configuration
- With `RUN_MON_STALL_CNT_EN` defined: `stall_count` increments (saturating) in RUN or SETTLE whenever `rob_count` ≠ 0 and `commit_valid` == 0. It clears on `start`.
- Without the macro: the port remains and is tied to 0, and no counter logic exists.

## Structure
- `run_mon_pkg` holds the state enum `run_mon_state_e` and the constant `NOP_INSTR`.
- One sub-module, `sat_counter`, is parametrised in width. It has clear, enable and increment-amount inputs and saturates at max. It is instantiated for the cycle, retired and stall counters.

## Test plan
- **Basic run:** `start`, then 20 cycles with `stage_valid`=3'b111, 5 single commits, then the drain condition. Expect `done` after 10 drained cycles, `retired_count`=5, `drain_cycle`=20.
- **Broken settle:** drain for 4 cycles, then `rob_count`=1 for 1 cycle, then drain again. Expect a return to RUN, `drain_cycle` re-captured at the second drain, and `done` 10 cycles after it.
- **Timeout:** `timeout_limit`=50, never drain. Expect `timeout`=1 and `cycle_count`=50, with counters frozen.
- **Timeout ties with drain:** at `cycle_count`=50 with `timeout_limit`=50, expect TIMEOUT to win.
- **Wide commit:** COMMIT_WIDTH=4, `commit_valid`=4'b1011 for 3 cycles. Expect `retired_count`=9.
- **Saturation and restart:** CNT_W=4 for 20 cycles. Expect `cycle_count` held at 15. Then `start` in DONE clears all counters. `rst` mid-SETTLE returns to IDLE with all outputs at 0.
